// File: rtl/inf_dff.sv
// rtl/inf_dff.sv - D-type register block with optional retiming stages
// Async active-high clear loads RESET_VALUE into every stage.
module inf_dff #(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= RESET_VALUE;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Output taken straight from the last flop; no path from din.
  assign dout = stage[STAGES-1];

endmodule

// File: tb/tb_inf_dff.sv
// tb/tb_inf_dff.sv - self-checking bench for inf_dff
// Default flop and an 8-bit three-stage pipe share one clock.
module tb_inf_dff;

  logic       clk = 1'b0;
  logic       rst1;
  logic       din1;
  logic       dout1;
  logic       rst3;
  logic [7:0] din3;
  logic [7:0] dout3;

  int checks = 0;
  int errors = 0;

  logic       q1 [$];
  logic [7:0] q3 [$];

  inf_dff u_dff (
    .clk  (clk),
    .rst  (rst1),
    .din  (din1),
    .dout (dout1)
  );

  inf_dff #(
    .WIDTH       (8),
    .STAGES      (3),
    .RESET_VALUE (8'hA5)
  ) u_pipe (
    .clk  (clk),
    .rst  (rst3),
    .din  (din3),
    .dout (dout3)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    rst1 = 1'b0;
    din1 = 1'b0;
    rst3 = 1'b1;
    din3 = 8'h00;
    #1;
    checks++;
    if (dout3 !== 8'hA5) begin
      errors++;
      $display("FAIL reset_pipe: dout=%h expected=%h", dout3, 8'hA5);
    end
  endtask

  task automatic test_basic_capture;
    logic [3:0] pattern = 4'b1101;
    logic exp;
    for (int i = 0; i < 4; i++) begin
      din1 = pattern[i];
      q1.push_back(pattern[i]);
      @(posedge clk);
      #1;
      exp = q1.pop_front();
      checks++;
      if (dout1 !== exp) begin
        errors++;
        $display("FAIL basic_capture[%0d]: dout=%b expected=%b", i, dout1, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset;
    #2;
    din1 = 1'b1;
    rst1 = 1'b1;
    q1.delete();
    #1;
    checks++;
    if (dout1 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_immediate: dout=%b expected=0", dout1);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (dout1 !== 1'b0) begin
        errors++;
        $display("FAIL async_reset_hold[%0d]: dout=%b expected=0", i, dout1);
      end
    end
  endtask

  task automatic test_reset_release;
    logic exp;
    @(negedge clk);
    #3;
    rst1 = 1'b0;
    din1 = 1'b1;
    q1.push_back(1'b1);
    #1;
    checks++;
    if (dout1 !== 1'b0) begin
      errors++;
      $display("FAIL release_before_edge: dout=%b expected=0", dout1);
    end
    @(posedge clk);
    #1;
    exp = q1.pop_front();
    checks++;
    if (dout1 !== exp) begin
      errors++;
      $display("FAIL release_first_capture: dout=%b expected=%b", dout1, exp);
    end
  endtask

  task automatic test_coincident_reset;
    @(negedge clk);
    din1 = 1'b0;
    @(negedge clk);
    din1 = 1'b1;
    @(posedge clk);
    rst1 = 1'b1;
    #1;
    checks++;
    if (dout1 !== 1'b0) begin
      errors++;
      $display("FAIL coincident_reset: dout=%b expected=0", dout1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dout1 !== 1'b0) begin
      errors++;
      $display("FAIL coincident_reset_hold: dout=%b expected=0", dout1);
    end
  endtask

  task automatic test_glitch;
    logic exp;
    @(negedge clk);
    rst1 = 1'b0;
    din1 = 1'b1;
    #1 din1 = 1'b0;
    #1 din1 = 1'b1;
    #1 din1 = 1'b0;
    checks++;
    if (dout1 !== 1'b0) begin
      errors++;
      $display("FAIL glitch_between_edges: dout=%b expected=0", dout1);
    end
    #1 din1 = 1'b1;
    q1.push_back(1'b1);
    @(posedge clk);
    #1;
    exp = q1.pop_front();
    checks++;
    if (dout1 !== exp) begin
      errors++;
      $display("FAIL glitch_capture: dout=%b expected=%b", dout1, exp);
    end
    #1 din1 = 1'b0;
    #1 din1 = 1'b1;
    #1;
    checks++;
    if (dout1 !== 1'b1) begin
      errors++;
      $display("FAIL glitch_no_passthrough: dout=%b expected=1", dout1);
    end
    q1.push_back(1'b1);
    @(posedge clk);
    #1;
    exp = q1.pop_front();
    checks++;
    if (dout1 !== exp) begin
      errors++;
      $display("FAIL glitch_hold: dout=%b expected=%b", dout1, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic b;
    logic exp;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      b = ($urandom_range(0, 1) != 0);
      din1 = b;
      q1.push_back(b);
      @(posedge clk);
      #1;
      exp = q1.pop_front();
      checks++;
      if (dout1 !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d]: dout=%b expected=%b", i, dout1, exp);
      end
    end
  endtask

  task automatic test_pipeline;
    logic [7:0] feed [8] = '{8'h3C, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h77, 8'h88};
    logic [7:0] exp;
    @(negedge clk);
    rst3 = 1'b0;
    q3.delete();
    q3.push_back(8'hA5);
    q3.push_back(8'hA5);
    for (int i = 0; i < 8; i++) begin
      din3 = feed[i];
      q3.push_back(feed[i]);
      @(posedge clk);
      #1;
      exp = q3.pop_front();
      checks++;
      if (dout3 !== exp) begin
        errors++;
        $display("FAIL pipe_latency[%0d]: dout=%h expected=%h", i, dout3, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pipe_flush;
    logic [7:0] feed [5] = '{8'h44, 8'h55, 8'h66, 8'h00, 8'h00};
    logic [7:0] exp;
    #2;
    rst3 = 1'b1;
    din3 = 8'hFF;
    #1;
    checks++;
    if (dout3 !== 8'hA5) begin
      errors++;
      $display("FAIL pipe_flush_immediate: dout=%h expected=%h", dout3, 8'hA5);
    end
    q3.delete();
    q3.push_back(8'hA5);
    q3.push_back(8'hA5);
    @(posedge clk);
    #1;
    checks++;
    if (dout3 !== 8'hA5) begin
      errors++;
      $display("FAIL pipe_flush_hold: dout=%h expected=%h", dout3, 8'hA5);
    end
    @(negedge clk);
    rst3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din3 = feed[i];
      q3.push_back(feed[i]);
      @(posedge clk);
      #1;
      exp = q3.pop_front();
      checks++;
      if (dout3 !== exp) begin
        errors++;
        $display("FAIL pipe_refill[%0d]: dout=%h expected=%h", i, dout3, exp);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_async_reset();
    test_reset_release();
    test_coincident_reset();
    test_glitch();
    test_back_to_back();
    test_pipeline();
    test_pipe_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

endmodule
